hazard_ctrl_unit: RTL

Parametrised successor to the pipeline forwarding logic. Combines EX-stage operand forwarding select, load-use stall detection and branch-taken flush with a sequential multi-cycle-operation (MDU) stall sequencer. Sits beside the 5-stage datapath. Drives forwarding muxes, PC/IF-ID/ID-EX enables and bubble/flush controls.

---
 rtl/hazard_ctrl_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall, branch flush
// and a multi-cycle (MDU) stall sequencer. Optional perf counters: HAZARD_PERF_EN.
module hazard_ctrl_unit #(
   parameter int ADDR_W      = 5,
   parameter int MDU_LATENCY = 4
) (
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic              in_exmem_regwrite,
   input  logic              in_memwb_regwrite,
   input  logic [ADDR_W-1:0] in_exmem_rd,
   input  logic [ADDR_W-1:0] in_memwb_rd,
   input  logic [ADDR_W-1:0] in_idex_rs1,
   input  logic [ADDR_W-1:0] in_idex_rs2,
   input  logic [ADDR_W-1:0] in_idex_rd,
   input  logic              in_idex_memread,
   input  logic              in_idex_mdu_start,
   input  logic [ADDR_W-1:0] in_ifid_rs1,
   input  logic [ADDR_W-1:0] in_ifid_rs2,
   input  logic              in_ifid_use_rs1,
   input  logic              in_ifid_use_rs2,
   input  logic              in_ex_branch_taken,
   output logic [1:0]        out_forwarda_sel,
   output logic [1:0]        out_forwardb_sel,
   output logic              out_pc_stall,
   output logic              out_ifid_stall,
   output logic              out_idex_stall,
   output logic              out_idex_bubble,
   output logic              out_exmem_bubble,
   output logic              out_ifid_flush,
   output logic              out_idex_flush,
   output logic              out_mdu_busy,
   output logic [31:0]       out_stall_count,
   output logic [31:0]       out_flush_count
);

   localparam int               CNT_W     = $clog2(MDU_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MDU_LATENCY - 1);
   localparam logic             MDU_MULTI = (MDU_LATENCY > 1);
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             mdu_stall_s;
   logic             lu_s;

   // Forwarding select: the younger EX/MEM result wins over MEM/WB
   always_comb begin
      out_forwarda_sel = 2'b00;
      out_forwardb_sel = 2'b00;
      if (in_exmem_regwrite && in_exmem_rd != REG_ZERO && in_exmem_rd == in_idex_rs1)
         out_forwarda_sel = 2'b10;
      else if (in_memwb_regwrite && in_memwb_rd != REG_ZERO && in_memwb_rd == in_idex_rs1)
         out_forwarda_sel = 2'b01;
      else
         out_forwarda_sel = 2'b00;
      if (in_exmem_regwrite && in_exmem_rd != REG_ZERO && in_exmem_rd == in_idex_rs2)
         out_forwardb_sel = 2'b10;
      else if (in_memwb_regwrite && in_memwb_rd != REG_ZERO && in_memwb_rd == in_idex_rs2)
         out_forwardb_sel = 2'b01;
      else
         out_forwardb_sel = 2'b00;
   end

   assign lu_s = in_idex_memread && (in_idex_rd != REG_ZERO) &&
                 ((in_ifid_use_rs1 && in_ifid_rs1 == in_idex_rd) ||
                  (in_ifid_use_rs2 && in_ifid_rs2 == in_idex_rd));

   // MDU sequencer next state; EX is frozen for the first MDU_LATENCY-1 cycles
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      mdu_stall_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_idex_mdu_start && !in_ex_branch_taken && MDU_MULTI) begin
               state_s     = BUSY;
               cnt_s       = CNT_LOAD;
               mdu_stall_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            mdu_stall_s = (cnt_r > CNT_W'(1));
            if (cnt_r <= CNT_W'(1)) begin
               state_s = IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r - CNT_W'(1);
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // Sequencer state register
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   assign out_mdu_busy = (state_r == BUSY);

   // Pipeline control priority: flush > MDU stall > load-use
   always_comb begin
      out_pc_stall     = 1'b0;
      out_ifid_stall   = 1'b0;
      out_idex_stall   = 1'b0;
      out_idex_bubble  = 1'b0;
      out_exmem_bubble = 1'b0;
      out_ifid_flush   = 1'b0;
      out_idex_flush   = 1'b0;
      if (in_ex_branch_taken) begin
         out_ifid_flush = 1'b1;
         out_idex_flush = 1'b1;
      end else if (mdu_stall_s) begin
         out_pc_stall     = 1'b1;
         out_ifid_stall   = 1'b1;
         out_idex_stall   = 1'b1;
         out_exmem_bubble = 1'b1;
      end else if (lu_s) begin
         out_pc_stall    = 1'b1;
         out_ifid_stall  = 1'b1;
         out_idex_bubble = 1'b1;
      end else begin
         out_pc_stall = 1'b0;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_r, flush_cnt_r;

   // Saturating stall/flush cycle counters
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (out_pc_stall && stall_cnt_r != 32'hFFFF_FFFF)
            stall_cnt_r <= stall_cnt_r + 32'd1;
         if (out_ifid_flush && flush_cnt_r != 32'hFFFF_FFFF)
            flush_cnt_r <= flush_cnt_r + 32'd1;
      end
   end

   assign out_stall_count = stall_cnt_r;
   assign out_flush_count = flush_cnt_r;
`else
   assign out_stall_count = 32'd0;
   assign out_flush_count = 32'd0;
`endif

endmodule
